// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage bundle widths and the packed payload
// structs that elastic stages carry between pipeline stages.
package pipe_pkg;

    localparam int FETCH_W     = 96;
    localparam int DECODE_W    = 376;
    localparam int EXEC_W      = 261;
    localparam int MEM_W       = 293;
    localparam int BACK_W      = 32;
    localparam int STALL_CNT_W = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } fetch_payload_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] pred_target;
        logic [31:0] csr_data;
        logic [11:0] csr_addr;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  alu_op;
        logic [31:0] ctrl;
        logic [7:0]  exc_cause;
        logic [47:0] trace_id;
    } decode_payload_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [31:0] branch_target;
        logic [31:0] csr_data;
        logic [11:0] csr_addr;
        logic [4:0]  rd;
        logic [27:0] ctrl;
        logic [7:0]  exc_cause;
        logic [47:0] trace_id;
    } exec_payload_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic [31:0] load_data;
        logic [31:0] csr_data;
        logic [31:0] mem_addr;
        logic [11:0] csr_addr;
        logic [4:0]  rd;
        logic [27:0] ctrl;
        logic [7:0]  exc_cause;
        logic [47:0] trace_id;
        logic [31:0] mem_wdata;
    } mem_payload_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter; holds at all-ones. Cleared only by async reset.
module pipe_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_elastic_stage.sv
// Elastic pipeline register: DEPTH-entry circular buffer between two stages,
// with synchronous flush and a saturating stall-cycle counter.
module pipe_elastic_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = 160,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [CNT_W-1:0]       count,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A transfer happens on a side exactly when valid and ready are both high
    // at the rising edge; valid never waits on ready. Both readies come from
    // the registered count only, so out_ready has no path to in_ready.
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem[head] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= next_ptr(tail);
            if (pop)  head <= next_ptr(head);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; out_data is masked while empty instead.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[tail] <= in_data;
        end
    end

    pipe_sat_counter #(
        .WIDTH(STALL_CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (out_valid & ~out_ready),
        .value(stall_cycles)
    );

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Directed bench for pipe_elastic_stage: DEPTH=2 and DEPTH=3 instances plus a
// narrow saturating counter, with a queue-based scoreboard on the DEPTH=3 stage.
module tb_pipe_elastic_stage;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // DEPTH=2 instance
    logic        flush2 = 1'b0, in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b1;
    logic [31:0] in_data2 = '0, out_data2, stall2;
    logic [1:0]  count2;

    // DEPTH=3 instance
    logic        flush3 = 1'b0, in_valid3 = 1'b0, in_ready3, out_valid3, out_ready3 = 1'b0;
    logic [31:0] in_data3 = '0, out_data3, stall3;
    logic [1:0]  count3;

    // narrow saturating counter
    logic       sat_inc = 1'b0;
    logic [3:0] sat_val;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_stall = '0;
    int          rx_cnt = 0;
    int          m_sz;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    pipe_elastic_stage #(.WIDTH(32), .DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .flush(flush2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .count(count2), .stall_cycles(stall2)
    );

    pipe_elastic_stage #(.WIDTH(32), .DEPTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .flush(flush3),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .count(count3), .stall_cycles(stall3)
    );

    pipe_sat_counter #(.WIDTH(4)) u_sat (
        .clk(clk), .rst(rst), .inc(sat_inc), .value(sat_val)
    );

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard for the DEPTH=3 stage; the model decides acceptance itself.
    always @(negedge clk) begin
        if (!rst) begin
            m_sz = exp_q.size();
            check_eq("count3", {62'd0, count3}, 64'(m_sz));
            check_eq("out_valid3", {63'd0, out_valid3}, {63'd0, m_sz != 0});
            check_eq("in_ready3", {63'd0, in_ready3}, {63'd0, m_sz != 3});
            check_eq("stall3", {32'd0, stall3}, {32'd0, exp_stall});
            if (m_sz != 0 && !out_ready3) exp_stall++;
            if (m_sz != 0 && out_ready3) begin
                check_eq("pop_data3", {32'd0, out_data3}, {32'd0, exp_q[0]});
                void'(exp_q.pop_front());
                rx_cnt++;
            end
            if (flush3) exp_q.delete();
            else if (in_valid3 && m_sz < 3) exp_q.push_back(in_data3);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        exp_stall = '0;
        check_eq("rst_out_valid3", {63'd0, out_valid3}, 64'd0);
        check_eq("rst_count3", {62'd0, count3}, 64'd0);
        check_eq("rst_out_data3", {32'd0, out_data3}, 64'd0);
        check_eq("rst_stall3", {32'd0, stall3}, 64'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic send3(input logic [31:0] v);
        logic ok;
        ok = 1'b0;
        in_valid3 = 1'b1;
        in_data3  = v;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready3;
            cyc();
        end
        in_valid3 = 1'b0;
        check_eq("send3_accept", {63'd0, ok}, 64'd1);
    endtask

    localparam logic [7:0] READY_PAT = 8'b1110_1101;

    // ---------------- stimulus ----------------
    initial begin
        // reset without any clock edge
        #3;
        rst = 1'b1;
        #1;
        check_eq("init_out_valid2", {63'd0, out_valid2}, 64'd0);
        check_eq("init_in_ready2", {63'd0, in_ready2}, 64'd1);
        check_eq("init_count2", {62'd0, count2}, 64'd0);
        check_eq("init_out_data2", {32'd0, out_data2}, 64'd0);
        check_eq("init_stall2", {32'd0, stall2}, 64'd0);
        check_eq("init_in_ready3", {63'd0, in_ready3}, 64'd1);
        check_eq("init_sat", {60'd0, sat_val}, 64'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;

        // single transfer through DEPTH=2
        cyc();
        in_valid2 = 1'b1;
        in_data2  = 32'hDEAD_BEEF;
        cyc();
        in_valid2 = 1'b0;
        check_eq("single_out_valid", {63'd0, out_valid2}, 64'd1);
        check_eq("single_out_data", {32'd0, out_data2}, 64'hDEAD_BEEF);
        check_eq("single_count1", {62'd0, count2}, 64'd1);
        cyc();
        check_eq("single_count0", {62'd0, count2}, 64'd0);
        check_eq("single_masked", {32'd0, out_data2}, 64'd0);

        // full throughput through DEPTH=2
        for (int k = 0; k < 6; k++) begin
            in_valid2 = 1'b1;
            in_data2  = 32'd100 + 32'(k);
            cyc();
            check_eq("tput_in_ready", {63'd0, in_ready2}, 64'd1);
            check_eq("tput_out_data", {32'd0, out_data2}, 64'd100 + 64'(k));
            check_eq("tput_count", {62'd0, count2}, 64'd1);
        end
        in_valid2 = 1'b0;
        cyc();
        check_eq("tput_drained", {62'd0, count2}, 64'd0);

        // fill and back-pressure on DEPTH=3
        apply_reset();
        cyc();
        out_ready3 = 1'b0;
        in_valid3  = 1'b1;
        for (int v = 1; v <= 3; v++) begin
            in_data3 = 32'(v);
            cyc();
        end
        in_data3 = 32'd4;
        check_eq("fill_count", {62'd0, count3}, 64'd3);
        check_eq("fill_in_ready", {63'd0, in_ready3}, 64'd0);
        check_eq("fill_stall_a", {32'd0, stall3}, 64'd2);
        cyc();
        cyc();
        check_eq("fill_stall_b", {32'd0, stall3}, 64'd4);
        check_eq("fill_held", {62'd0, count3}, 64'd3);
        check_eq("fill_head", {32'd0, out_data3}, 64'd1);
        out_ready3 = 1'b1;
        cyc();
        check_eq("fill_pop1_head", {32'd0, out_data3}, 64'd2);
        cyc();
        in_valid3 = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        check_eq("fill_rx", 64'(rx_cnt), 64'd4);
        check_eq("fill_stall_end", {32'd0, stall3}, 64'd4);

        // wrap-around with toggling out_ready
        apply_reset();
        begin
            int rx_base;
            rx_base = rx_cnt;
            fork
                for (int v = 0; v < 10; v++) send3(32'(v));
                for (int i = 0; i < 60; i++) begin
                    out_ready3 = READY_PAT[i % 8];
                    cyc();
                end
            join
            out_ready3 = 1'b1;
            for (int i = 0; i < 5; i++) cyc();
            check_eq("wrap_rx", 64'(rx_cnt - rx_base), 64'd10);
            check_eq("wrap_empty", 64'(exp_q.size()), 64'd0);
        end

        // flush with a simultaneous push
        apply_reset();
        cyc();
        out_ready3 = 1'b0;
        in_valid3  = 1'b1;
        in_data3   = 32'hAAAA_0001;
        cyc();
        in_data3   = 32'hBBBB_0002;
        cyc();
        check_eq("flush_pre_count", {62'd0, count3}, 64'd2);
        in_data3   = 32'hCCCC_0003;
        flush3     = 1'b1;
        cyc();
        flush3     = 1'b0;
        in_valid3  = 1'b0;
        check_eq("flush_count", {62'd0, count3}, 64'd0);
        check_eq("flush_out_valid", {63'd0, out_valid3}, 64'd0);
        check_eq("flush_stall", {32'd0, stall3}, 64'd2);
        out_ready3 = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        check_eq("flush_no_c", {63'd0, out_valid3}, 64'd0);
        check_eq("flush_stall_hold", {32'd0, stall3}, 64'd2);

        // reset while entries are buffered
        out_ready3 = 1'b0;
        in_valid3  = 1'b1;
        in_data3   = 32'd5;
        cyc();
        in_data3   = 32'd6;
        cyc();
        in_valid3  = 1'b0;
        apply_reset();

        // saturation of a narrow counter
        cyc();
        sat_inc = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        check_eq("sat_mid", {60'd0, sat_val}, 64'd5);
        for (int i = 0; i < 15; i++) cyc();
        check_eq("sat_full", {60'd0, sat_val}, 64'hF);
        for (int i = 0; i < 3; i++) cyc();
        check_eq("sat_hold_inc", {60'd0, sat_val}, 64'hF);
        sat_inc = 1'b0;
        cyc();
        check_eq("sat_hold_idle", {60'd0, sat_val}, 64'hF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_elastic_stage.md
Name: pipe_elastic_stage

Overview:
Parametrised elastic pipeline register placed between two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It replaces a bare stage latch with a DEPTH-entry circular buffer under a valid/ready handshake, plus synchronous flush and a saturating stall-cycle counter. The payload is a flat packed vector sized from the stage bundle widths in the shared package. in_ready depends only on registered state, so there is no combinational path from out_ready to in_ready and the stall loop is cut.

Parameters:
WIDTH, 160, payload width in bits; must be ≥1.
DEPTH, 2, number of buffer entries; must be ≥1; any value allowed, no power-of-2 requirement.
CNT_W, $clog2(DEPTH+1), occupancy counter width; derived, do not override.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous discard of all buffered entries
in_valid  input  1  upstream presents payload
in_ready  output  1  stage can accept payload this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  head entry available downstream
out_ready  input  1  downstream accepts head entry
out_data  output  WIDTH  head entry payload
count  output  CNT_W  current occupancy, 0..DEPTH
stall_cycles  output  32  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset (async, rst=1): head=0, tail=0, count=0, stall_cycles=0. Outputs: out_valid=0, in_ready=1, out_data=0. Buffer storage is not reset.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (count != DEPTH). Registered-derived only.
- out_valid = (count != 0). out_data = mem[head] when out_valid=1, else 0 (masked).
- Latency: a push into an empty stage is visible on out_valid/out_data in the next cycle (1 cycle). Throughput is 1 per cycle when DEPTH ≥ 2 under continuous out_ready. DEPTH=1 alternates and gives 1 per 2 cycles under back-pressure-free flow, because a full slot blocks in_ready.
- Push: mem[tail] <= in_data. tail <= (tail==DEPTH-1) ? 0 : tail+1.
- Pop: head advances with the same explicit wrap at DEPTH-1.
- count update: +1 on push only, −1 on pop only, unchanged when both or neither.
- Simultaneous push and pop:
  - When 0 < count < DEPTH: both occur and count is unchanged.
  - When count=DEPTH: push is impossible because in_ready=0.
  - When count=0: pop is impossible; there is no fall-through bypass.
- Flush (synchronous):
  - Next cycle head=0, tail=0, count=0.
  - A push presented in the flush cycle is dropped.
  - A pop in the flush cycle is still a completed handshake for downstream, and that entry is consumed.
  - stall_cycles is not cleared by flush.
- Priority: rst > flush > push/pop.
- stall_cycles: increments in every cycle where out_valid & ~out_ready. It saturates at 32'hFFFF_FFFF and holds there. It counts in flush cycles too, since it is evaluated on current outputs.
- Reset asserted mid-transfer: all state clears immediately and asynchronously. Buffered entries are lost, and out_valid falls in the same cycle.
- Protocol assertions for the bench:
  - in_data must be stable while in_valid & ~in_ready.
  - The stage guarantees out_data/out_valid stable while out_valid & ~out_ready, with no flush.

Decomposition:
- Shared package pipe_pkg holds:
  - localparam widths FETCH_W=96, DECODE_W=376, EXEC_W=261, MEM_W=293, BACK_W=32.
  - Packed struct typedefs fetch_payload_t, decode_payload_t, exec_payload_t, mem_payload_t, mirroring the stage bundles.
  - STALL_CNT_W=32.
- Instantiation: stages instantiate pipe_elastic_stage with WIDTH=$bits(<payload_t>).
- Sub-module: one natural sub-module, pipe_sat_counter (WIDTH param, inc, clr via rst only, saturating), used for stall_cycles. Pointer/count logic stays inline.

Test Plan:
- Reset, then idle: rst pulse mid-cycle -> out_valid=0, in_ready=1, count=0, out_data=0, stall_cycles=0, with no clock edge needed.
- Single transfer, DEPTH=2, out_ready=1: push 32'hDEADBEEF (WIDTH=32) at cycle 0 -> out_valid=1, out_data=32'hDEADBEEF at cycle 1, and count returns to 0 at cycle 2.
- Fill and back-pressure, DEPTH=3, out_ready=0: push 1, 2, 3 -> count=3, in_ready=0. The 4th value 4 is held and not accepted. stall_cycles increments each cycle. Releasing out_ready pops 1, 2, 3, 4 in order.
- Wrap-around, DEPTH=3: continuous push/pop of 10 values 0..9 with out_ready toggling 1,0,1,1,... -> output order 0..9 exact, and count never exceeds 3.
- Flush with simultaneous push, count=2 holding A, B: flush=1 with in_valid=1 carrying C -> next cycle count=0, out_valid=0, C never appears, and stall_cycles is unchanged by flush.
- Saturation: force stall for 2^32+5 cycles (or preload via test hook) -> stall_cycles=32'hFFFF_FFFF and holds.
